sequenciador_rpn: RTL and testbench
===================================

// Module: sequenciador_rpn
// PURPOSE
//   Parametrised RPN entry sequencer between the switch bank and the ALU.
//   - Owns its step counter and registers each RPN field from entrada_sw on a confirm edge: A, then B, then op/carry.
//   - Presents the stable operand set to the ALU through a valid/ready handshake.
//   - Optional chaining mode feeds the ALU result back as the next A, for continuous RPN entry.
// PARAMETERS
//   LARGURA        8         operand width; must satisfy LARGURA >= LARGURA_SEL+1
//   LARGURA_SEL    3         ALU operation-select width
//   MASCARA_UNARIA 8'h80     bit k=1 -> op k is unary; saida_b forced to 0 (width 2**LARGURA_SEL)
//   ENCADEAR       0         1 -> after handshake, load resultado_ula into A and go to CAP_B
// PORTS
//   clk             in   1            system clock, rising edge
//   reset_n         in   1            asynchronous reset, active low
//   entrada_sw      in   LARGURA      switch data (debounced externally)
//   confirmar       in   1            level; rising edge advances one step
//   voltar          in   1            level; rising edge goes back one step
//   resultado_ula   in   LARGURA      ALU result, sampled on handshake when ENCADEAR=1
//   ula_pronta      in   1            ALU ready (handshake)
//   saida_a         out  LARGURA      registered operand A
//   saida_b         out  LARGURA      registered operand B (0 when op is unary)
//   saida_sel       out  LARGURA_SEL  registered op select
//   saida_carry_in  out  1            registered carry in
//   operacao_valida out  1            operand set valid for the ALU (handshake)
//   passo           out  2            current state code, for display
// BEHAVIOUR
//   Reset (async, reset_n=0): all outputs 0; state CAP_A; edge-detect history registers cleared to 0.
//   Edge detect: ev = x & ~x_q, where x_q is x registered once.
//     - ev fires on the first clk edge at which x is sampled 1 after being sampled 0.
//     - Capture and state change happen on that same edge; outputs update right after it.
//   States (code = passo):
//     CAP_A=00, CAP_B=01, CAP_OP=10, EXEC=11.
//   Confirm transitions:
//     - CAP_A: saida_a<=entrada_sw; go to CAP_B.
//     - CAP_B: b_reg<=entrada_sw; go to CAP_OP.
//     - CAP_OP: saida_sel<=sw[LARGURA_SEL-1:0], saida_carry_in<=sw[LARGURA_SEL]; go to EXEC.
//   Back transitions (voltar):
//     - CAP_B -> CAP_A; CAP_OP -> CAP_B.
//     - Ignored in CAP_A and EXEC.
//     - Captured registers keep their values when stepping back; they are overwritten on re-confirm.
//   Simultaneous confirm and back edges: no action; both histories still update.
//   EXEC handshake:
//     - operacao_valida=1 for as long as the state is EXEC.
//     - Transfer occurs on the first edge with operacao_valida & ula_pronta.
//     - saida_a/b/sel/carry stay stable from entry to EXEC until transfer.
//     - Confirm and back edges are ignored while in EXEC.
//     - ula_pronta already 1 on entry -> transfer on the next edge (1-cycle valid).
//   After transfer:
//     - ENCADEAR=0: go to CAP_A; operand registers retain their values.
//     - ENCADEAR=1: saida_a<=resultado_ula; go to CAP_B.
//     - operacao_valida drops in both cases.
//   saida_b = MASCARA_UNARIA[saida_sel] ? 0 : b_reg (combinational mask on the registered value).
//   Reset mid-EXEC: immediate return to the reset state; the transfer is lost.
//   No arithmetic; width checks are done by an elaboration-time assertion on LARGURA >= LARGURA_SEL+1.
// STRUCTURE
//   Package rpn_pkg: localparams CAP_A/CAP_B/CAP_OP/EXEC (2-bit state codes), default LARGURA/LARGURA_SEL.
//     Shared with the display decoder that shows passo.
//   Sub-module detector_borda: 1-bit rising-edge detector with async active-low reset.
//     Instantiated twice (confirmar, voltar).
//   Top: one state register, operand/op registers, output mask logic.
// TESTING
//   1. Reset, sw=0x25 confirm, sw=0x13 confirm, sw=0x08 confirm
//        -> A=0x25, B=0x13, sel=0, carry=1, passo=11, valid=1.
//   2. In EXEC, hold ula_pronta=0 for 5 cycles, then 1
//        -> valid high for all 5 cycles, operands stable; passo=00 after transfer.
//   3. Enter A=0x10 and B=0x20, back edge, sw=0x30 confirm
//        -> B=0x30, A unchanged; confirm and back on the same edge -> passo unchanged.
//   4. Op sel=7 (unary per default mask) with B=0xFF -> saida_b=0x00 in EXEC.
//   5. ENCADEAR=1, resultado_ula=0x5A at transfer -> A=0x5A, passo=01, valid=0.
//   6. reset_n low mid-EXEC (asynchronous, between clock edges) -> all outputs 0 immediately, passo=00.
//      confirmar held high across reset release -> no capture until a fresh 0->1.

Source files
------------

// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - step codes and default widths shared by the RPN sequencer and the step display
package rpn_pkg;
  localparam int LARGURA_PADRAO     = 8;
  localparam int LARGURA_SEL_PADRAO = 3;

  typedef enum logic [1:0] {
    CAP_A  = 2'b00,
    CAP_B  = 2'b01,
    CAP_OP = 2'b10,
    EXEC   = 2'b11
  } estado_t;
endpackage

// File: rtl/detector_borda.sv
// rtl/detector_borda.sv - rising-edge detector for one level input
module detector_borda (
  input  logic clk,
  input  logic reset_n,
  input  logic x,
  output logic ev
);
  logic x_q;
  logic armado;

  // armado stays low for the first edge after reset, so a level already high
  // at reset release is not taken as a fresh press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= 1'b0;
      armado <= 1'b0;
    end else begin
      x_q    <= x;
      armado <= 1'b1;
    end
  end

  assign ev = x & ~x_q & armado;
endmodule

// File: rtl/sequenciador_rpn.sv
// rtl/sequenciador_rpn.sv - RPN entry sequencer: captures A, B, op/carry and hands them to the ALU
module sequenciador_rpn
  import rpn_pkg::*;
#(
  parameter int                          LARGURA        = LARGURA_PADRAO,
  parameter int                          LARGURA_SEL    = LARGURA_SEL_PADRAO,
  parameter logic [2**LARGURA_SEL-1:0]   MASCARA_UNARIA = 'h80,
  parameter bit                          ENCADEAR       = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LARGURA-1:0]     entrada_sw,
  input  logic                   confirmar,
  input  logic                   voltar,
  input  logic [LARGURA-1:0]     resultado_ula,
  input  logic                   ula_pronta,
  output logic [LARGURA-1:0]     saida_a,
  output logic [LARGURA-1:0]     saida_b,
  output logic [LARGURA_SEL-1:0] saida_sel,
  output logic                   saida_carry_in,
  output logic                   operacao_valida,
  output logic [1:0]             passo
);
  if (LARGURA < LARGURA_SEL + 1) begin : g_largura_invalida
    $error("sequenciador_rpn: LARGURA must be >= LARGURA_SEL+1");
  end

  estado_t          estado, estado_prox;
  logic             ev_conf, ev_volt;
  logic             conf_ok, volt_ok;
  logic             cap_a, cap_b, cap_op, carrega_res;
  logic [LARGURA-1:0] b_reg;

  detector_borda u_borda_conf (.clk(clk), .reset_n(reset_n), .x(confirmar), .ev(ev_conf));
  detector_borda u_borda_volt (.clk(clk), .reset_n(reset_n), .x(voltar),    .ev(ev_volt));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) estado <= CAP_A;
    else          estado <= estado_prox;
  end

  // Simultaneous confirm and back cancel each other.
  always_comb begin
    estado_prox = estado;
    cap_a       = 1'b0;
    cap_b       = 1'b0;
    cap_op      = 1'b0;
    carrega_res = 1'b0;
    conf_ok     = ev_conf & ~ev_volt;
    volt_ok     = ev_volt & ~ev_conf;
    case (estado)
      CAP_A: begin
        if (conf_ok) begin
          cap_a       = 1'b1;
          estado_prox = CAP_B;
        end
      end
      CAP_B: begin
        if (conf_ok) begin
          cap_b       = 1'b1;
          estado_prox = CAP_OP;
        end else if (volt_ok) begin
          estado_prox = CAP_A;
        end
      end
      CAP_OP: begin
        if (conf_ok) begin
          cap_op      = 1'b1;
          estado_prox = EXEC;
        end else if (volt_ok) begin
          estado_prox = CAP_B;
        end
      end
      EXEC: begin
        if (ula_pronta) begin
          if (ENCADEAR) begin
            carrega_res = 1'b1;
            estado_prox = CAP_B;
          end else begin
            estado_prox = CAP_A;
          end
        end
      end
      default: estado_prox = CAP_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      saida_a        <= '0;
      b_reg          <= '0;
      saida_sel      <= '0;
      saida_carry_in <= 1'b0;
    end else begin
      if (cap_a)       saida_a <= entrada_sw;
      if (carrega_res) saida_a <= resultado_ula;
      if (cap_b)       b_reg   <= entrada_sw;
      if (cap_op) begin
        saida_sel      <= entrada_sw[LARGURA_SEL-1:0];
        saida_carry_in <= entrada_sw[LARGURA_SEL];
      end
    end
  end

  assign saida_b         = MASCARA_UNARIA[saida_sel] ? '0 : b_reg;
  assign operacao_valida = (estado == EXEC);
  assign passo           = estado;
endmodule

// File: tb/tb_sequenciador_rpn.sv
// tb/tb_sequenciador_rpn.sv - self-checking bench for sequenciador_rpn (plain and chained instances)
module tb_sequenciador_rpn;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sw = '0;
  logic       conf = 1'b0;
  logic       volt = 1'b0;
  logic [7:0] res = '0;
  logic       pronta = 1'b0;

  logic [7:0] a_o [2];
  logic [7:0] b_o [2];
  logic [2:0] sel_o [2];
  logic       cy_o [2];
  logic       v_o [2];
  logic [1:0] p_o [2];
  logic [22:0] obs [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ma [2];
  logic [7:0] mb [2];
  logic [2:0] msel [2];
  logic       mc [2];
  logic [1:0] mst [2];

  always #5 clk = ~clk;

  sequenciador_rpn #(.ENCADEAR(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .entrada_sw(sw), .confirmar(conf), .voltar(volt),
    .resultado_ula(res), .ula_pronta(pronta), .saida_a(a_o[0]), .saida_b(b_o[0]),
    .saida_sel(sel_o[0]), .saida_carry_in(cy_o[0]), .operacao_valida(v_o[0]), .passo(p_o[0])
  );

  sequenciador_rpn #(.ENCADEAR(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .entrada_sw(sw), .confirmar(conf), .voltar(volt),
    .resultado_ula(res), .ula_pronta(pronta), .saida_a(a_o[1]), .saida_b(b_o[1]),
    .saida_sel(sel_o[1]), .saida_carry_in(cy_o[1]), .operacao_valida(v_o[1]), .passo(p_o[1])
  );

  assign obs[0] = {a_o[0], b_o[0], sel_o[0], cy_o[0], v_o[0], p_o[0]};
  assign obs[1] = {a_o[1], b_o[1], sel_o[1], cy_o[1], v_o[1], p_o[1]};

  // Reference model: steps are A(0) B(1) OP(2) EXEC(3); op 7 is unary under the default mask.
  function automatic logic [22:0] expv(int i);
    logic [7:0] bb;
    bb = (msel[i] == 3'd7) ? 8'h00 : mb[i];
    return {ma[i], bb, msel[i], mc[i], (mst[i] == 2'd3), mst[i]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      ma[i] = '0; mb[i] = '0; msel[i] = '0; mc[i] = 1'b0; mst[i] = 2'd0;
    end
  endtask

  task automatic m_confirm(input logic [7:0] v);
    for (int i = 0; i < 2; i++) begin
      case (mst[i])
        2'd0: begin ma[i] = v; mst[i] = 2'd1; end
        2'd1: begin mb[i] = v; mst[i] = 2'd2; end
        2'd2: begin msel[i] = v[2:0]; mc[i] = v[3]; mst[i] = 2'd3; end
        default: ;
      endcase
    end
  endtask

  task automatic m_back();
    for (int i = 0; i < 2; i++)
      if (mst[i] == 2'd1 || mst[i] == 2'd2) mst[i] = mst[i] - 2'd1;
  endtask

  task automatic m_transfer(input logic [7:0] r);
    if (mst[0] == 2'd3) mst[0] = 2'd0;
    if (mst[1] == 2'd3) begin ma[1] = r; mst[1] = 2'd1; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; conf = 1'b0; volt = 1'b0; pronta = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic press(input logic c, input logic b, input logic [7:0] v);
    @(negedge clk);
    sw = v; conf = c; volt = b;
    @(negedge clk);
    conf = 1'b0; volt = 1'b0;
    if (c && !b) m_confirm(v);
    else if (b && !c) m_back();
  endtask

  task automatic transfer(input int espera, input logic [7:0] r);
    for (int k = 0; k < espera; k++) @(negedge clk);
    @(negedge clk);
    pronta = 1'b1; res = r;
    @(negedge clk);
    pronta = 1'b0;
    m_transfer(r);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs[i] !== 23'd0) begin
        n_fail++; $display("FAIL reset dut%0d got %h expected %h", i, obs[i], 23'd0);
      end
    end
  endtask

  task automatic test_entry();
    do_reset();
    press(1, 0, 8'h25); press(1, 0, 8'h13); press(1, 0, 8'h08);
    n_tests++;
    if (obs[0] !== {8'h25, 8'h13, 3'd0, 1'b1, 1'b1, 2'b11}) begin
      n_fail++; $display("FAIL entry got %h expected %h", obs[0], {8'h25, 8'h13, 3'd0, 1'b1, 1'b1, 2'b11});
    end
  endtask

  task automatic test_hold();
    logic [22:0] snap;
    snap = expv(0);
    pronta = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs[0] !== snap) begin
        n_fail++; $display("FAIL hold cycle %0d got %h expected %h", k, obs[0], snap);
      end
    end
    transfer(0, 8'hC3);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs[i] !== expv(i)) begin
        n_fail++; $display("FAIL hold_transfer dut%0d got %h expected %h", i, obs[i], expv(i));
      end
    end
    n_tests++;
    if (p_o[0] !== 2'b00 || v_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL hold_after passo %b valid %b expected 00 0", p_o[0], v_o[0]);
    end
  endtask

  task automatic test_back();
    do_reset();
    press(1, 0, 8'h10); press(1, 0, 8'h20); press(0, 1, 8'h00); press(1, 0, 8'h30);
    n_tests++;
    if (a_o[0] !== 8'h10 || b_o[0] !== 8'h30 || p_o[0] !== 2'b10) begin
      n_fail++; $display("FAIL back got A=%h B=%h passo=%b expected A=10 B=30 passo=10", a_o[0], b_o[0], p_o[0]);
    end
    press(1, 1, 8'h55);
    n_tests++;
    if (obs[0] !== expv(0) || p_o[0] !== 2'b10) begin
      n_fail++; $display("FAIL both_edges got %h expected %h", obs[0], expv(0));
    end
  endtask

  task automatic test_unary();
    do_reset();
    press(1, 0, 8'h44); press(1, 0, 8'hFF); press(1, 0, 8'h07);
    n_tests++;
    if (b_o[0] !== 8'h00 || sel_o[0] !== 3'd7 || p_o[0] !== 2'b11) begin
      n_fail++; $display("FAIL unary got B=%h sel=%0d passo=%b expected B=00 sel=7 passo=11", b_o[0], sel_o[0], p_o[0]);
    end
  endtask

  task automatic test_chain();
    do_reset();
    press(1, 0, 8'h11); press(1, 0, 8'h22); press(1, 0, 8'h03);
    transfer(2, 8'h5A);
    n_tests++;
    if (a_o[1] !== 8'h5A || p_o[1] !== 2'b01 || v_o[1] !== 1'b0) begin
      n_fail++; $display("FAIL chain got A=%h passo=%b valid=%b expected A=5a passo=01 valid=0", a_o[1], p_o[1], v_o[1]);
    end
  endtask

  task automatic test_ready_early();
    do_reset();
    press(1, 0, 8'h31); press(1, 0, 8'h42);
    pronta = 1'b1;
    press(1, 0, 8'h01);
    n_tests++;
    if (v_o[0] !== 1'b1 || p_o[0] !== 2'b11) begin
      n_fail++; $display("FAIL early_valid got valid=%b passo=%b expected 1 11", v_o[0], p_o[0]);
    end
    @(negedge clk);
    pronta = 1'b0;
    m_transfer(res);
    n_tests++;
    if (v_o[0] !== 1'b0 || p_o[0] !== 2'b00) begin
      n_fail++; $display("FAIL early_transfer got valid=%b passo=%b expected 0 00", v_o[0], p_o[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    press(1, 0, 8'h9A); press(1, 0, 8'hBC); press(1, 0, 8'h05);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    conf = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs[i] !== 23'd0) begin
        n_fail++; $display("FAIL async_reset dut%0d got %h expected 0", i, obs[i]);
      end
    end
    m_reset();
    @(negedge clk);
    sw = 8'hEE;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (p_o[0] !== 2'b00 || a_o[0] !== 8'h00) begin
      n_fail++; $display("FAIL held_confirm got passo=%b A=%h expected 00 00", p_o[0], a_o[0]);
    end
    conf = 1'b0;
    press(1, 0, 8'h77);
    n_tests++;
    if (a_o[0] !== 8'h77 || p_o[0] !== 2'b01) begin
      n_fail++; $display("FAIL fresh_confirm got A=%h passo=%b expected 77 01", a_o[0], p_o[0]);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      press(1, 0, 8'($urandom));
      else if (r <= 6) press(0, 1, 8'($urandom));
      else if (r == 7) press(1, 1, 8'($urandom));
      else             transfer($urandom_range(0, 3), 8'($urandom));
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (obs[i] !== expv(i)) begin
          n_fail++; $display("FAIL random step %0d dut%0d got %h expected %h", n, i, obs[i], expv(i));
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_entry();
    test_hold();
    test_back();
    test_unary();
    test_chain();
    test_ready_early();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
